// File: rtl/alu_pipe.sv
// Pipelined ALU: single-cycle logic/arithmetic ops, iterative shift-add multiply,
// valid/ready handshake on both sides with a one-entry result register.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Sel,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow,
    output logic             Negative,
    output logic             Err
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;

    logic [WIDTH-1:0]   r_out;
    logic               r_out_valid;
    logic               r_zero;
    logic               r_carry;
    logic               r_ovf;
    logic               r_neg;
    logic               r_err;

    logic               w_accept;
    logic               w_is_mul;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic               w_mul_hi;

    logic signed [WIDTH-1:0] w_a_s;
    logic signed [WIDTH-1:0] w_b_s;
    logic [WIDTH:0]          w_sum;
    logic [WIDTH:0]          w_diff;
    logic [WIDTH-1:0]        w_res;
    logic                    w_c;
    logic                    w_v;
    logic                    w_e;

    assign In_ready   = (r_state == S_IDLE) && (!r_out_valid || Out_ready);
    assign w_accept   = In_valid && In_ready;
    assign w_is_mul   = (Sel == OP_MUL);
    assign w_mul_done = (r_state == S_BUSY) && (r_cnt == '0);

    assign w_a_s  = A;
    assign w_b_s  = B;
    assign w_sum  = {1'b0, A} + {1'b0, B};
    assign w_diff = {1'b0, A} - {1'b0, B};

    // Single-cycle opcodes; MUL is finished by the iterative datapath below.
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_e   = 1'b0;
        case (Sel)
            OP_AND: w_res = A & B;
            OP_OR:  w_res = A | B;
            OP_XOR: w_res = A ^ B;
            OP_NOR: w_res = ~(A | B);
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, (w_a_s < w_b_s)};
            OP_MUL: w_res = '0;
            default: w_e = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_is_mul) w_state_nxt = S_BUSY;
            S_BUSY: if (r_cnt == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cnt <= '0;
        end else if (w_accept && w_is_mul) begin
            r_cnt <= CNT_W'(WIDTH - 1);
        end else if (r_state == S_BUSY && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Shift-add: one multiplier bit per BUSY cycle; the last partial sum is
    // taken combinationally so the result lands on the final BUSY edge.
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_hi  = |w_acc_nxt[2*WIDTH-1:WIDTH];

    always_ff @(posedge Clk) begin
        if (w_accept && w_is_mul) begin
            r_mcand  <= {{WIDTH{1'b0}}, A};
            r_mplier <= B;
            r_acc    <= '0;
        end else if (r_state == S_BUSY) begin
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_acc    <= w_acc_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_neg       <= 1'b0;
            r_err       <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_out       <= w_res;
            r_out_valid <= 1'b1;
            r_zero      <= (w_res == '0);
            r_carry     <= w_c;
            r_ovf       <= w_v;
            r_neg       <= w_res[WIDTH-1];
            r_err       <= w_e;
        end else if (w_mul_done) begin
            r_out       <= w_acc_nxt[WIDTH-1:0];
            r_out_valid <= 1'b1;
            r_zero      <= (w_acc_nxt[WIDTH-1:0] == '0);
            r_carry     <= w_mul_hi;
            r_ovf       <= w_mul_hi;
            r_neg       <= w_acc_nxt[WIDTH-1];
            r_err       <= 1'b0;
        end else if (r_out_valid && Out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign Out       = r_out;
    assign Out_valid = r_out_valid;
    assign Zero      = r_zero;
    assign Carry     = r_carry;
    assign Overflow  = r_ovf;
    assign Negative  = r_neg;
    assign Err       = r_err;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH = 8): directed vectors, MUL timing,
// backpressure, async reset during MUL, and randomized scoreboard run.
module tb_alu_pipe;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Rst_n;
    logic         In_valid;
    logic         In_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   Sel;
    logic         Out_valid;
    logic         Out_ready;
    logic [W-1:0] Out;
    logic         Zero, Carry, Overflow, Negative, Err;

    logic [12:0]  obs;
    int           total = 0;
    int           bad   = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .In_valid(In_valid), .In_ready(In_ready),
        .A(A), .B(B), .Sel(Sel), .Out_valid(Out_valid), .Out_ready(Out_ready),
        .Out(Out), .Zero(Zero), .Carry(Carry), .Overflow(Overflow),
        .Negative(Negative), .Err(Err)
    );

    always #5 Clk = ~Clk;

    assign obs = {Out, Zero, Carry, Overflow, Negative, Err};

    // Reference: {out, zero, carry, overflow, negative, err}
    function automatic logic [12:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] sel);
        int ua, ub, sa, sb, r;
        logic [7:0] o;
        logic c, v, e;
        ua = a; ub = b;
        sa = (ua > 127) ? ua - 256 : ua;
        sb = (ub > 127) ? ub - 256 : ub;
        c = 0; v = 0; e = 0; o = 0;
        case (sel)
            4'd0:  o = a & b;
            4'd1:  o = a | b;
            4'd3:  o = a ^ b;
            4'd12: o = ~(a | b);
            4'd2: begin
                r = ua + ub; o = 8'(r); c = (r > 255);
                v = (sa + sb > 127) || (sa + sb < -128);
            end
            4'd6: begin
                r = ua - ub; o = 8'(r); c = (ua < ub);
                v = (sa - sb > 127) || (sa - sb < -128);
            end
            4'd7: o = (sa < sb) ? 8'd1 : 8'd0;
            4'd8: begin
                r = ua * ub; o = 8'(r); c = (r > 255); v = c;
            end
            default: e = 1;
        endcase
        return {o, (o == 8'd0), c, v, o[7], e};
    endfunction

    localparam int ND = 8;
    localparam logic [7:0]  DA [ND] = '{8'h55, 8'hF7, 8'h7F, 8'hFF, 8'hAA, 8'h00, 8'hAA, 8'h0F};
    localparam logic [7:0]  DB [ND] = '{8'hAA, 8'hFD, 8'h01, 8'hFF, 8'h55, 8'h01, 8'hFF, 8'hF0};
    localparam logic [3:0]  DS [ND] = '{4'd2, 4'd2, 4'd2, 4'd6, 4'd15, 4'd6, 4'd3, 4'd12};
    localparam logic [12:0] DE [ND] = '{{8'hFF, 5'b00010}, {8'hF4, 5'b01010},
                                        {8'h80, 5'b00110}, {8'h00, 5'b10000},
                                        {8'h00, 5'b10001}, {8'hFF, 5'b01010},
                                        {8'h55, 5'b00000}, {8'h00, 5'b10000}};

    task automatic test_reset();
        Rst_n = 1'b0; In_valid = 1'b0; Out_ready = 1'b1; A = '0; B = '0; Sel = '0;
        #2;
        total++;
        if ({Out_valid, obs} !== 14'd0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", {Out_valid, obs});
        end
        @(posedge Clk); @(posedge Clk); #1;
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        total++;
        if (In_ready !== 1'b1 || Out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", In_ready, Out_valid);
        end
    endtask

    task automatic test_directed();
        for (int i = 0; i < ND; i++) begin
            total++;
            if (In_ready !== 1'b1) begin
                bad++; $display("FAIL dir_ready[%0d]: got %b want 1", i, In_ready);
            end
            A = DA[i]; B = DB[i]; Sel = DS[i]; In_valid = 1'b1;
            @(posedge Clk); #1;
            In_valid = 1'b0;
            total++;
            if (Out_valid !== 1'b1 || obs !== DE[i]) begin
                bad++; $display("FAIL dir_result[%0d]: got v=%b %h want v=1 %h", i, Out_valid, obs, DE[i]);
            end
        end
        @(posedge Clk); #1;
        total++;
        if (Out_valid !== 1'b0) begin
            bad++; $display("FAIL dir_drain: out_valid got %b want 0", Out_valid);
        end
    endtask

    task automatic test_mul();
        logic [7:0]  ma [2] = '{8'h0C, 8'h10};
        logic [7:0]  mb [2] = '{8'h0B, 8'h10};
        logic [12:0] me [2] = '{{8'h84, 5'b00010}, {8'h00, 5'b11100}};
        for (int m = 0; m < 2; m++) begin
            A = ma[m]; B = mb[m]; Sel = 4'd8; In_valid = 1'b1;
            @(posedge Clk); #1;
            // keep offering an ADD while busy; it must be ignored
            A = 8'h01; B = 8'h01; Sel = 4'd2;
            for (int k = 1; k <= W; k++) begin
                total++;
                if (In_ready !== 1'b0 || Out_valid !== 1'b0) begin
                    bad++; $display("FAIL mul_busy[%0d] edge %0d: rdy=%b vld=%b want 0/0", m, k, In_ready, Out_valid);
                end
                if (k < W) begin
                    @(posedge Clk); #1;
                end
            end
            @(posedge Clk); #1;
            In_valid = 1'b0;
            total++;
            if (Out_valid !== 1'b1 || obs !== me[m]) begin
                bad++; $display("FAIL mul_result[%0d]: got v=%b %h want v=1 %h", m, Out_valid, obs, me[m]);
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_backpressure();
        Out_ready = 1'b0;
        A = 8'h55; B = 8'hAA; Sel = 4'd2; In_valid = 1'b1;
        @(posedge Clk); #1;
        A = 8'hCC; B = 8'hAA; Sel = 4'd0;
        for (int k = 0; k < 5; k++) begin
            @(posedge Clk); #1;
            total++;
            if (Out_valid !== 1'b1 || obs !== {8'hFF, 5'b00010} || In_ready !== 1'b0) begin
                bad++; $display("FAIL stall[%0d]: v=%b %h rdy=%b want v=1 %h rdy=0", k, Out_valid, obs, In_ready, {8'hFF, 5'b00010});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ba [3] = '{8'hCC, 8'hCC, 8'hF7};
        logic [7:0]  bb [3] = '{8'hAA, 8'hAA, 8'h03};
        logic [3:0]  bs [3] = '{4'd0, 4'd1, 4'd7};
        logic [12:0] be [3] = '{{8'h88, 5'b00010}, {8'hEE, 5'b00010}, {8'h01, 5'b00000}};
        Out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            A = ba[i]; B = bb[i]; Sel = bs[i]; In_valid = 1'b1;
            #1;
            total++;
            if (In_ready !== 1'b1) begin
                bad++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, In_ready);
            end
            @(posedge Clk); #1;
            total++;
            if (Out_valid !== 1'b1 || obs !== be[i]) begin
                bad++; $display("FAIL b2b_result[%0d]: got v=%b %h want v=1 %h", i, Out_valid, obs, be[i]);
            end
        end
        In_valid = 1'b0;
        @(posedge Clk); #1;
        total++;
        if (Out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_drain: out_valid got %b want 0", Out_valid);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic seen;
        A = 8'h0C; B = 8'h0B; Sel = 4'd8; In_valid = 1'b1;
        @(posedge Clk); #1;
        In_valid = 1'b0;
        repeat (3) @(posedge Clk);
        #3;
        Rst_n = 1'b0;
        #1;
        total++;
        if ({Out_valid, obs} !== 14'd0) begin
            bad++; $display("FAIL rst_async: got %h want 0", {Out_valid, obs});
        end
        @(posedge Clk); @(posedge Clk); #1;
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        total++;
        if (In_ready !== 1'b1 || Out_valid !== 1'b0) begin
            bad++; $display("FAIL rst_release: rdy=%b vld=%b want 1/0", In_ready, Out_valid);
        end
        seen = 1'b0;
        for (int k = 0; k < W + 4; k++) begin
            @(posedge Clk); #1;
            if (Out_valid !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++; $display("FAIL rst_no_result: got stray out_valid want none");
        end
    endtask

    task automatic test_random();
        logic [12:0] q[$];
        logic [12:0] exp_v;
        logic [3:0]  legal [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd8, 4'd12};
        int          n_acc = 0;
        for (int i = 0; i < 400; i++) begin
            In_valid  = ($urandom_range(0, 3) != 0);
            A         = 8'($urandom);
            B         = 8'($urandom);
            Sel       = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 7)] : 4'($urandom_range(0, 15));
            if (Sel == 4'd8 && $urandom_range(0, 3) != 0) Sel = 4'd2;
            Out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (Out_valid && Out_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rnd_unexpected[%0d]: got %h want no result", i, obs);
                end else begin
                    exp_v = q.pop_front();
                    if (obs !== exp_v) begin
                        bad++; $display("FAIL rnd_result[%0d]: got %h want %h", i, obs, exp_v);
                    end
                end
            end
            if (In_valid && In_ready) begin
                q.push_back(model(A, B, Sel));
                n_acc++;
            end
            @(posedge Clk); #1;
        end
        In_valid  = 1'b0;
        Out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (Out_valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL rnd_drain_extra: got %h want no result", obs);
                end else begin
                    exp_v = q.pop_front();
                    if (obs !== exp_v) begin
                        bad++; $display("FAIL rnd_drain: got %h want %h", obs, exp_v);
                    end
                end
            end
            @(posedge Clk); #1;
        end
        total++;
        if (q.size() != 0 || n_acc == 0) begin
            bad++; $display("FAIL rnd_leftover: got %0d pending (%0d accepted) want 0 pending", q.size(), n_acc);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mul();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_mul();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
